// File: rtl/sha3_inv_rho_pi.sv
// sha3_inv_rho_pi: iterative inverse of the Keccak rho+pi step.
// Captures a post-rho-pi state P[s][c] on an accepted sample, then rebuilds
// the pre-rho-pi state S[x][y] = rotr(P[(2*(y-x)) mod 5][x], R[x][y]),
// SLICES_PER_CYCLE output slices (one slice = one x) per cycle.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   isa..ise [5]        post-rho-pi rows s=0..4, lane c=0..4
//   sample              capture request, honoured only while ready
//   ready               idle, will accept sample this cycle
//   osa..ose [5]        pre-rho-pi output, os<x>[y] = S[x][y]
//   good                one-cycle pulse, os* hold a complete result
//   overrun             sticky, sample seen while busy
module sha3_inv_rho_pi #(
  parameter  int unsigned SLICES_PER_CYCLE = 1,
  localparam int unsigned LANE_W           = 64,
  localparam int unsigned N_LANE           = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LANE_W-1:0] isa [N_LANE],
  input  logic [LANE_W-1:0] isb [N_LANE],
  input  logic [LANE_W-1:0] isc [N_LANE],
  input  logic [LANE_W-1:0] isd [N_LANE],
  input  logic [LANE_W-1:0] ise [N_LANE],
  input  logic              sample,
  output logic              ready,
  output logic [LANE_W-1:0] osa [N_LANE],
  output logic [LANE_W-1:0] osb [N_LANE],
  output logic [LANE_W-1:0] osc [N_LANE],
  output logic [LANE_W-1:0] osd [N_LANE],
  output logic [LANE_W-1:0] ose [N_LANE],
  output logic              good,
  output logic              overrun
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned ROT_W = 6;

  // Right-rotation amounts, indexed [x][y].
  localparam logic [ROT_W-1:0] ROT [N_LANE][N_LANE] = '{
    '{6'd0,  6'd1,  6'd62, 6'd28, 6'd27},
    '{6'd36, 6'd44, 6'd6,  6'd55, 6'd20},
    '{6'd3,  6'd10, 6'd43, 6'd25, 6'd39},
    '{6'd41, 6'd45, 6'd15, 6'd21, 6'd8 },
    '{6'd18, 6'd2,  6'd61, 6'd56, 6'd14}
  };

  if (!(SLICES_PER_CYCLE == 1 || SLICES_PER_CYCLE == 5)) begin : g_bad_param
    $error("sha3_inv_rho_pi: SLICES_PER_CYCLE must be 1 or 5");
  end

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COMPUTE = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_last;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_good;
  logic              r_overrun;
  logic [LANE_W-1:0] r_p [N_LANE][N_LANE];  // [row s][lane c]

  // Rotate right; a zero amount shifts the left term out entirely.
  function automatic logic [LANE_W-1:0] rotr(input logic [LANE_W-1:0] v,
                                             input logic [ROT_W-1:0]  r);
    rotr = (v >> r) | (v << (7'd64 - {1'b0, r}));
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: accept in IDLE, leave COMPUTE on the edge that writes slice 4.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sample) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        w_last = (32'(r_cnt) + SLICES_PER_CYCLE) >= N_LANE;
        if (w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Input buffer, slice counter and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p       <= '{default: '0};
      r_cnt     <= '0;
      r_good    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_good <= w_last;
      if (sample && (r_state == ST_COMPUTE)) r_overrun <= 1'b1;
      if (w_accept) begin
        r_p[0] <= isa;
        r_p[1] <= isb;
        r_p[2] <= isc;
        r_p[3] <= isd;
        r_p[4] <= ise;
        r_cnt  <= '0;
      end else if (r_state == ST_COMPUTE) begin
        r_cnt <= r_cnt + CNT_W'(SLICES_PER_CYCLE);
      end
    end
  end

  // One output slice per x; it only sees column x of the buffer.
  for (genvar gx = 0; gx < N_LANE; gx++) begin : g_slice
    logic [LANE_W-1:0] w_rot [N_LANE];
    logic [LANE_W-1:0] r_os  [N_LANE];
    logic              w_we;

    for (genvar gy = 0; gy < N_LANE; gy++) begin : g_lane
      localparam int unsigned SRC_ROW = (2 * gy + 10 - 2 * gx) % 5;
      assign w_rot[gy] = rotr(r_p[SRC_ROW][gx], ROT[gx][gy]);
    end

    // Slice gx is written while it lies in the window cnt .. cnt+SPC-1.
    assign w_we = (r_state == ST_COMPUTE) && (32'(r_cnt) <= gx) &&
                  (gx < (32'(r_cnt) + SLICES_PER_CYCLE));

    always_ff @(posedge clk) begin
      if (rst)       r_os <= '{default: '0};
      else if (w_we) r_os <= w_rot;
    end
  end

  assign osa     = g_slice[0].r_os;
  assign osb     = g_slice[1].r_os;
  assign osc     = g_slice[2].r_os;
  assign osd     = g_slice[3].r_os;
  assign ose     = g_slice[4].r_os;
  assign ready   = (r_state == ST_IDLE);
  assign good    = r_good;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_sha3_inv_rho_pi.sv
// tb_sha3_inv_rho_pi: randomized self-checking bench for sha3_inv_rho_pi.
// Two instances (SLICES_PER_CYCLE = 1 and 5) share clk/rst and are exercised
// one after the other against a lane-level rho-pi reference model.
module tb_sha3_inv_rho_pi;

  typedef logic [63:0] st_t [5][5];

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] t_is [2][5][5];   // [unit][row s][lane c]
  logic [63:0] t_os [2][5][5];   // [unit][x][y]
  logic [1:0]  sample;
  logic [1:0]  ready;
  logic [1:0]  good;
  logic [1:0]  overrun;

  int n_checks = 0;
  int n_errors = 0;

  int rtab [5][5] = '{
    '{0, 1, 62, 28, 27},
    '{36, 44, 6, 55, 20},
    '{3, 10, 43, 25, 39},
    '{41, 45, 15, 21, 8},
    '{18, 2, 61, 56, 14}
  };

  st_t rt_s [200];
  st_t rt_p [200];

  always #5 clk = ~clk;

  for (genvar u = 0; u < 2; u++) begin : g_dut
    sha3_inv_rho_pi #(.SLICES_PER_CYCLE(u == 0 ? 1 : 5)) dut (
      .clk     (clk),
      .rst     (rst),
      .isa     (t_is[u][0]),
      .isb     (t_is[u][1]),
      .isc     (t_is[u][2]),
      .isd     (t_is[u][3]),
      .ise     (t_is[u][4]),
      .sample  (sample[u]),
      .ready   (ready[u]),
      .osa     (t_os[u][0]),
      .osb     (t_os[u][1]),
      .osc     (t_os[u][2]),
      .osd     (t_os[u][3]),
      .ose     (t_os[u][4]),
      .good    (good[u]),
      .overrun (overrun[u])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rotr_m(input logic [63:0] v, input int r);
    logic [127:0] d;
    d = {v, v} >> r;
    return d[63:0];
  endfunction

  function automatic logic [63:0] rotl_m(input logic [63:0] v, input int r);
    return rotr_m(v, (64 - r) % 64);
  endfunction

  // Reference inverse: S[x][y] = rotr(P[(2*(y-x)) mod 5][x], R[x][y]).
  task automatic inv_model(input st_t p, output st_t s);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[x][y] = rotr_m(p[(2 * (y - x) + 10) % 5][x], rtab[x][y]);
  endtask

  // Forward rho-pi written as the mapping S -> P.
  task automatic fwd_model(input st_t s, output st_t p);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        p[(2 * (y - x) + 10) % 5][x] = rotl_m(s[x][y], rtab[x][y]);
  endtask

  task automatic rand_state(output st_t s);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        s[i][j] = {$urandom, $urandom};
  endtask

  task automatic zero_state(output st_t s);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        s[i][j] = '0;
  endtask

  task automatic check_out(input int u, input st_t exp, input string tag);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        check($sformatf("%s u%0d os[%0d][%0d]", tag, u, x, y), t_os[u][x][y], exp[x][y]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    sample = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One isolated job: checks latency to good, the result and the pulse width.
  task automatic run_single(input int u, input st_t p, input string tag);
    st_t e;
    st_t junk;
    int  n;
    bit  found;
    @(negedge clk);
    t_is[u]   = p;
    sample[u] = 1'b1;
    @(posedge clk);
    #1;
    sample[u] = 1'b0;
    rand_state(junk);
    t_is[u] = junk;
    n     = 0;
    found = 1'b0;
    while (n < 20 && !found) begin
      @(posedge clk);
      #1;
      n++;
      if (good[u]) found = 1'b1;
    end
    check($sformatf("%s u%0d latency", tag, u), 64'(n), (u == 0) ? 64'd5 : 64'd1);
    inv_model(p, e);
    check_out(u, e, tag);
    @(posedge clk);
    #1;
    check($sformatf("%s u%0d good_pulse", tag, u), 64'(good[u]), 64'd0);
  endtask

  initial begin
    st_t p;
    st_t s;
    st_t e;
    st_t a;
    st_t b;
    int  idx_in;
    int  idx_out;
    int  cyc;
    int  ng;
    int  off;
    bit  acc;

    rst    = 1'b1;
    sample = '0;
    for (int u = 0; u < 2; u++) begin
      zero_state(p);
      t_is[u] = p;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int u = 0; u < 2; u++) begin
      check($sformatf("rst u%0d ready", u), 64'(ready[u]), 64'd1);
      check($sformatf("rst u%0d good", u), 64'(good[u]), 64'd0);
      check($sformatf("rst u%0d overrun", u), 64'(overrun[u]), 64'd0);
      zero_state(e);
      check_out(u, e, "rst");
    end

    for (int u = 0; u < 2; u++) begin
      zero_state(p);
      p[1][0] = 64'd1;
      run_single(u, p, "isb0");
      check($sformatf("isb0 u%0d osa3", u), t_os[u][0][3], 64'h0000_0010_0000_0000);

      zero_state(p);
      p[4][4] = 64'd1;
      run_single(u, p, "ise4");
      check($sformatf("ise4 u%0d ose1", u), t_os[u][4][1], 64'h4000_0000_0000_0000);

      zero_state(p);
      p[0][0] = 64'hDEAD_BEEF_0123_4567;
      run_single(u, p, "isa0");
      check($sformatf("isa0 u%0d osa0", u), t_os[u][0][0], 64'hDEAD_BEEF_0123_4567);

      for (int si = 0; si < 5; si++) begin
        for (int ci = 0; ci < 5; ci++) begin
          zero_state(p);
          p[si][ci] = 64'd1 << $urandom_range(63, 0);
          run_single(u, p, $sformatf("walk%0d%0d", si, ci));
        end
      end
    end

    // Round trip with sample held high: jobs accepted back to back.
    for (int u = 0; u < 2; u++) begin
      do_reset();
      for (int j = 0; j < 200; j++) begin
        rand_state(s);
        rt_s[j] = s;
        fwd_model(s, p);
        rt_p[j] = p;
      end
      @(negedge clk);
      idx_in    = 0;
      idx_out   = 0;
      cyc       = 0;
      t_is[u]   = rt_p[0];
      sample[u] = 1'b1;
      while (idx_out < 200 && cyc < 2000) begin
        acc = sample[u] && ready[u];
        @(posedge clk);
        #1;
        cyc++;
        if (good[u]) begin
          check_out(u, rt_s[idx_out], $sformatf("rt%0d", idx_out));
          idx_out++;
        end
        @(negedge clk);
        if (acc) begin
          idx_in++;
          if (idx_in < 200) t_is[u] = rt_p[idx_in];
          else              sample[u] = 1'b0;
        end
      end
      sample[u] = 1'b0;
      check($sformatf("rt u%0d jobs", u), 64'(idx_out), 64'd200);
      check($sformatf("rt u%0d cycles", u), 64'(cyc), (u == 0) ? 64'd1200 : 64'd400);
    end

    // Overrun: second sample while busy is dropped and flagged.
    for (int u = 0; u < 2; u++) begin
      do_reset();
      rand_state(a);
      rand_state(b);
      inv_model(a, e);
      off = (u == 0) ? 2 : 1;
      @(negedge clk);
      t_is[u]   = a;
      sample[u] = 1'b1;
      @(posedge clk);
      ng = 0;
      for (int k = 1; k <= 60; k++) begin
        @(negedge clk);
        if (k == off) begin
          t_is[u]   = b;
          sample[u] = 1'b1;
        end else begin
          sample[u] = 1'b0;
          rand_state(p);
          t_is[u] = p;
        end
        @(posedge clk);
        #1;
        if (good[u]) ng++;
      end
      check($sformatf("ovr u%0d goods", u), 64'(ng), 64'd1);
      check_out(u, e, "ovr");
      check($sformatf("ovr u%0d overrun", u), 64'(overrun[u]), 64'd1);
    end

    // Reset at T+3 aborts the job; a simultaneous sample must lose to rst.
    do_reset();
    rand_state(a);
    @(negedge clk);
    t_is[0]   = a;
    sample[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b1;
    sample[0] = 1'b1;
    rand_state(p);
    t_is[0] = p;
    @(posedge clk);
    #1;
    check("midrst good", 64'(good[0]), 64'd0);
    check("midrst ready", 64'(ready[0]), 64'd1);
    check("midrst overrun", 64'(overrun[0]), 64'd0);
    zero_state(e);
    check_out(0, e, "midrst");
    @(negedge clk);
    rst       = 1'b0;
    sample[0] = 1'b0;
    ng        = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (good[0]) ng++;
    end
    check("midrst no_good", 64'(ng), 64'd0);
    rand_state(b);
    run_single(0, b, "postrst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
